// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch front end.
// Contents: default address width, opcode field bounds, NOP encoding and
// the fetch FSM state type.
package fetch_pkg;

   localparam int unsigned ADDR_W_DEFAULT = 32;
   localparam int unsigned INSTR_W        = 32;
   localparam int unsigned OPCODE_MSB     = 31;
   localparam int unsigned OPCODE_LSB     = 26;

   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StWait,
      StFull
   } fetch_state_e;

endpackage

// File: rtl/fetch_buffer.sv
// Synchronous FIFO holding fetched {instruction, pc+4} entries.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   flush_i      empty the FIFO (wins over push_i and pop_i)
//   push_i       write data_i at the tail
//   data_i       entry to write
//   pop_i        drop the head entry
//   head_o       head entry (only meaningful while count_o != 0)
//   count_o      number of valid entries, 0..DEPTH
// The caller guarantees no push when full and no pop when empty.
module fetch_buffer #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         head_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // DEPTH is a power of two, so pointers wrap by overflow.
         if (push_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
         if (pop_i)  rd_ptr_d = rd_ptr_q + PtrW'(1);
         count_d = count_q + CntW'(push_i) - CntW'(pop_i);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues single-outstanding
// requests to instruction memory, buffers responses and hands them to decode.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   imem_req_valid/ready/addr   fetch request channel (word-aligned address)
//   imem_rsp_valid/data         one response per accepted request
//   id_valid/ready              decode handshake; pop on valid && ready
//   id_instr/opcode/pc_plus4    head instruction, its opcode field, its pc+4
//   redirect_valid/pc           branch redirect pulse; flushes buffer and
//                               squashes any in-flight response
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned       ADDR_W   = ADDR_W_DEFAULT,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int unsigned       DEPTH    = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [ADDR_W-1:0] imem_req_addr,
   input  logic              imem_rsp_valid,
   input  logic [31:0]       imem_rsp_data,
   output logic              id_valid,
   input  logic              id_ready,
   output logic [31:0]       id_instr,
   output logic [5:0]        id_opcode,
   output logic [ADDR_W-1:0] id_pc_plus4,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc
);

   localparam int unsigned     CntW     = $clog2(DEPTH) + 1;
   localparam int unsigned     EntryW   = INSTR_W + ADDR_W;
   localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   // Set when the outstanding response belongs to a redirected-away path.
   logic              kill_q, kill_d;

   logic [CntW-1:0]   count;
   logic [CntW-1:0]   count_after;
   logic [EntryW-1:0] head;
   logic [ADDR_W-1:0] pc_plus4;
   logic              push, pop;

   assign pc_plus4 = pc_q + ADDR_W'(4);
   assign id_valid = (count != '0);
   // Redirect flushes the buffer, so a same-cycle pop or push is meaningless.
   assign pop      = id_valid & id_ready & ~redirect_valid;
   assign push     = (state_q == StWait) & imem_rsp_valid & ~kill_q & ~redirect_valid;
   assign count_after = count + CntW'(push) - CntW'(pop);

   fetch_buffer #(
      .DEPTH (DEPTH),
      .WIDTH (EntryW)
   ) u_buffer (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (redirect_valid),
      .push_i  (push),
      .data_i  ({imem_rsp_data, pc_plus4}),
      .pop_i   (pop),
      .head_o  (head),
      .count_o (count)
   );

   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      kill_d         = kill_q;
      imem_req_valid = 1'b0;

      unique case (state_q)
         StIdle: state_d = StReq;
         StReq: begin
            imem_req_valid = 1'b1;
            if (imem_req_ready) state_d = StWait;
         end
         StWait: begin
            if (imem_rsp_valid) begin
               if (kill_q) begin
                  kill_d  = 1'b0;
                  state_d = StReq;
               end else begin
                  pc_d    = pc_plus4;
                  state_d = (count_after < DepthCnt) ? StReq : StFull;
               end
            end
         end
         StFull: if (count < DepthCnt) state_d = StReq;
         default: state_d = StIdle;
      endcase

      if (redirect_valid) begin
         pc_d = redirect_pc & ~ADDR_W'(3);
         unique case (state_q)
            StReq: begin
               // An accepted request to the old address still owes a response.
               state_d = imem_req_ready ? StWait : StReq;
               kill_d  = imem_req_ready;
            end
            StWait: begin
               state_d = imem_rsp_valid ? StReq : StWait;
               kill_d  = ~imem_rsp_valid;
            end
            default: begin
               state_d = StReq;
               kill_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         pc_q    <= RESET_PC;
         kill_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         kill_q  <= kill_d;
      end
   end

   assign imem_req_addr = pc_q;
   // Outputs read as zero when nothing is buffered.
   assign id_instr      = id_valid ? head[EntryW-1:ADDR_W] : NOP_INSTR;
   assign id_opcode     = id_instr[OPCODE_MSB:OPCODE_LSB];
   assign id_pc_plus4   = id_valid ? head[ADDR_W-1:0] : '0;

endmodule
